// File: rtl/layer_param_streamer.sv
// Run-time loadable weight/bias store that streams one NN layer as
// {weight, bias, neuron, input} beats over a valid/ready handshake.
module layer_param_streamer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_LAYERS = 5,
    parameter int unsigned LN_W       = 6,
    parameter int unsigned WT_DEPTH   = 512,
    parameter int unsigned BIAS_DEPTH = 64,
    parameter int unsigned WT_AW      = $clog2(WT_DEPTH),
    parameter int unsigned B_AW       = $clog2(BIAS_DEPTH),
    parameter int unsigned LAYER_W    = $clog2(MAX_LAYERS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LN_W*(MAX_LAYERS+1)-1:0] cfg_sizes,
    input  logic                           wr_en,
    input  logic                           wr_sel,
    input  logic [WT_AW-1:0]               wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_err,
    input  logic                           start,
    input  logic [LAYER_W-1:0]             layer,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_wt,
    output logic [DATA_W-1:0]              out_bias,
    output logic [LN_W-1:0]                out_neuron,
    output logic [LN_W-1:0]                out_input,
    output logic                           out_last_in,
    output logic                           out_last
);

    localparam int unsigned SZ_W    = LN_W * (MAX_LAYERS + 1);
    // Wide enough for the sum of all size products plus one more, so base math never wraps.
    localparam int unsigned ACC_RAW = 2 * LN_W + LAYER_W + 1;
    localparam int unsigned ACC_W   = (ACC_RAW > WT_AW + 1) ? ACC_RAW : WT_AW + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StStream, StDrain} state_e;

    typedef struct packed {
        logic [LN_W-1:0] neuron;
        logic [LN_W-1:0] inp;
        logic            last_in;
        logic            last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] wt;
        logic [DATA_W-1:0] bias;
        tag_t              tag;
    } beat_t;

    function automatic logic [LN_W-1:0] size_at(input logic [SZ_W-1:0]    sizes,
                                                input logic [LAYER_W-1:0] k);
        logic [LN_W-1:0] r;
        r = '0;
        for (int n = 0; n < int'(MAX_LAYERS) + 1; n++) begin
            if (k == LAYER_W'(n)) r = sizes[n*LN_W +: LN_W];
        end
        return r;
    endfunction

    state_e state_q, state_d;
    logic   calc_en, stream_en, drain_en;

    logic [LAYER_W-1:0] layer_q, layer_d, k_q, k_d;
    logic [ACC_W-1:0]   wb_q, wb_d, bb_q, bb_d;
    logic [LN_W-1:0]    nin_q, nin_d, nout_q, nout_d;
    logic [LN_W-1:0]    i_q, i_d, j_q, j_d;
    logic [WT_AW-1:0]   wt_addr_q, wt_addr_d;
    logic [B_AW-1:0]    b_addr_q, b_addr_d;

    logic              rd_vld_q, rd_vld_d;
    tag_t              rd_tag_q, rd_tag_d;
    logic [DATA_W-1:0] wt_rd_q, bias_rd_q;

    beat_t [1:0] fifo_q, fifo_d;
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    beat_t       head;

    logic cfg_err_q, cfg_err_d, wr_err_q, wr_err_d, done_q, done_d;

    logic [DATA_W-1:0] wt_mem   [WT_DEPTH];
    logic [DATA_W-1:0] bias_mem [BIAS_DEPTH];

    // Start decode: layer range and zero sizes are rejected before leaving idle.
    logic [LN_W-1:0] start_nin, start_nout, calc_nin, calc_nout, acc_prev, acc_cur;
    logic            layer_ok, start_req, start_ok, calc_last, range_bad;
    logic            pop, issue, last_in_now, last_now, wr_bad, wr_ok;
    logic [2:0]      occ;

    always_comb begin
        start_nin  = size_at(cfg_sizes, layer - LAYER_W'(1));
        start_nout = size_at(cfg_sizes, layer);
        layer_ok   = (layer != '0) && (layer <= LAYER_W'(MAX_LAYERS));
        start_req  = (state_q == StIdle) && start;
        start_ok   = start_req && layer_ok && (start_nin != '0) && (start_nout != '0);

        calc_nin   = size_at(cfg_sizes, layer_q - LAYER_W'(1));
        calc_nout  = size_at(cfg_sizes, layer_q);
        acc_prev   = size_at(cfg_sizes, k_q - LAYER_W'(1));
        acc_cur    = size_at(cfg_sizes, k_q);
        calc_last  = (k_q == layer_q);
        range_bad  = (wb_q + ACC_W'(calc_nin) * ACC_W'(calc_nout) > ACC_W'(WT_DEPTH)) ||
                     (bb_q + ACC_W'(calc_nout) > ACC_W'(BIAS_DEPTH));

        head        = fifo_q[rd_ptr_q];
        pop         = (cnt_q != 2'd0) && out_ready;
        // Entries queued or in flight after this edge; a new read needs room for itself.
        occ         = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        issue       = stream_en && (occ <= 3'd1);
        last_in_now = (i_q == nin_q - LN_W'(1));
        last_now    = last_in_now && (j_q == nout_q - LN_W'(1));

        wr_bad = wr_en && (busy || (wr_sel ? (32'(wr_addr) >= BIAS_DEPTH)
                                           : (32'(wr_addr) >= WT_DEPTH)));
        wr_ok  = wr_en && !wr_bad;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_ok) state_d = StCalc;
            StCalc:   if (calc_last) state_d = range_bad ? StIdle : StStream;
            StStream: if (issue && last_now) state_d = StDrain;
            StDrain:  if (pop && head.tag.last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = 1'b0;
        calc_en   = 1'b0;
        stream_en = 1'b0;
        drain_en  = 1'b0;
        unique case (state_q)
            StIdle:   ;
            StCalc:   begin busy = 1'b1; calc_en   = 1'b1; end
            StStream: begin busy = 1'b1; stream_en = 1'b1; end
            StDrain:  begin busy = 1'b1; drain_en  = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        layer_d   = layer_q;
        k_d       = k_q;
        wb_d      = wb_q;
        bb_d      = bb_q;
        nin_d     = nin_q;
        nout_d    = nout_q;
        i_d       = i_q;
        j_d       = j_q;
        wt_addr_d = wt_addr_q;
        b_addr_d  = b_addr_q;

        if (start_ok) begin
            layer_d = layer;
            k_d     = LAYER_W'(1);
            wb_d    = '0;
            bb_d    = '0;
        end

        if (calc_en && !calc_last) begin
            wb_d = wb_q + ACC_W'(acc_prev) * ACC_W'(acc_cur);
            bb_d = bb_q + ACC_W'(acc_cur);
            k_d  = k_q + LAYER_W'(1);
        end else if (calc_en) begin
            nin_d     = calc_nin;
            nout_d    = calc_nout;
            wt_addr_d = wb_q[WT_AW-1:0];
            b_addr_d  = bb_q[B_AW-1:0];
            i_d       = '0;
            j_d       = '0;
        end

        // Row-major order makes the weight address a plain running counter.
        if (issue) begin
            wt_addr_d = wt_addr_q + WT_AW'(1);
            if (last_in_now) begin
                i_d      = '0;
                j_d      = j_q + LN_W'(1);
                b_addr_d = b_addr_q + B_AW'(1);
            end else begin
                i_d = i_q + LN_W'(1);
            end
        end

        rd_vld_d = issue;
        rd_tag_d = rd_tag_q;
        if (issue) begin
            rd_tag_d.neuron  = j_q;
            rd_tag_d.inp     = i_q;
            rd_tag_d.last_in = last_in_now;
            rd_tag_d.last    = last_now;
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rd_vld_q) begin
            fifo_d[wr_ptr_q] = '{wt: wt_rd_q, bias: bias_rd_q, tag: rd_tag_q};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + 2'(rd_vld_q) - 2'(pop);

        cfg_err_d = (start_req && !start_ok) || (calc_en && calc_last && range_bad);
        wr_err_d  = wr_bad;
        done_d    = drain_en && pop && head.tag.last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_q   <= '0;
            k_q       <= '0;
            wb_q      <= '0;
            bb_q      <= '0;
            nin_q     <= '0;
            nout_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            wt_addr_q <= '0;
            b_addr_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_tag_q  <= '0;
            fifo_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            cfg_err_q <= 1'b0;
            wr_err_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            layer_q   <= layer_d;
            k_q       <= k_d;
            wb_q      <= wb_d;
            bb_q      <= bb_d;
            nin_q     <= nin_d;
            nout_q    <= nout_d;
            i_q       <= i_d;
            j_q       <= j_d;
            wt_addr_q <= wt_addr_d;
            b_addr_q  <= b_addr_d;
            rd_vld_q  <= rd_vld_d;
            rd_tag_q  <= rd_tag_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
            wr_err_q  <= wr_err_d;
            done_q    <= done_d;
        end
    end

    // Storage is not reset; reads have one cycle of latency.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_sel) wt_mem[wr_addr] <= wr_data;
        if (wr_ok && wr_sel)  bias_mem[wr_addr[B_AW-1:0]] <= wr_data;
        if (issue) begin
            wt_rd_q   <= wt_mem[wt_addr_q];
            bias_rd_q <= bias_mem[b_addr_q];
        end
    end

    always_comb begin
        out_valid   = (cnt_q != 2'd0);
        out_wt      = out_valid ? head.wt : '0;
        out_bias    = out_valid ? head.bias : '0;
        out_neuron  = out_valid ? head.tag.neuron : '0;
        out_input   = out_valid ? head.tag.inp : '0;
        out_last_in = out_valid && head.tag.last_in;
        out_last    = out_valid && head.tag.last;
        cfg_err     = cfg_err_q;
        wr_err      = wr_err_q;
        done        = done_q;
    end

endmodule

// File: tb/tb_layer_param_streamer.sv
// Directed bench for layer_param_streamer: loads a 3-4-2 network and checks
// streamed beats, handshake stalls, config rejects, load errors and reset.
module tb_layer_param_streamer;

    localparam int DATA_W = 16;
    localparam int LN_W = 6;
    localparam int MAXL = 5;
    localparam int WT_AW = 9;
    localparam int LAYER_W = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [LN_W*(MAXL+1)-1:0] cfg_sizes;
    logic                     wr_en, wr_sel;
    logic [WT_AW-1:0]         wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_err;
    logic                     start;
    logic [LAYER_W-1:0]       layer;
    logic                     busy, done, cfg_err, out_valid, out_ready;
    logic [DATA_W-1:0]        out_wt, out_bias;
    logic [LN_W-1:0]          out_neuron, out_input;
    logic                     out_last_in, out_last;

    int n_checks = 0;
    int n_fail = 0;

    layer_param_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_sizes   (cfg_sizes),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .start       (start),
        .layer       (layer),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wt      (out_wt),
        .out_bias    (out_bias),
        .out_neuron  (out_neuron),
        .out_input   (out_input),
        .out_last_in (out_last_in),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_sizes(input int s0, input int s1, input int s2);
        cfg_sizes = '0;
        cfg_sizes[0 +: LN_W] = LN_W'(s0);
        cfg_sizes[LN_W +: LN_W] = LN_W'(s1);
        cfg_sizes[2*LN_W +: LN_W] = LN_W'(s2);
    endtask

    task automatic do_write(input logic sel, input int addr, input int data, input logic exp_err,
                            input string tag);
        @(negedge clk);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = WT_AW'(addr);
        wr_data = DATA_W'(data);
        @(negedge clk);
        wr_en = 1'b0;
        check_eq(tag, 64'(wr_err), 64'(exp_err));
    endtask

    // mode 0: out_ready held high; mode 1: out_ready 1,0,0,1 repeating.
    // rst_beat > 0: assert rst while that beat is presented. wr_cyc > 0: load attempt then.
    task automatic stream_layer(input int lay, input int nin, input int nout, input int wb,
                                input int bias0, input int mode, input int rst_beat,
                                input int wr_cyc);
        int cyc, nb, first_v, last_acc, done_cyc, nvalid, ii, jj;
        logic stall_prev, aborted, seen_bad;
        logic [63:0] prev_pack, cur_pack;
        nb = 0; first_v = -1; last_acc = -1; done_cyc = -1; nvalid = 0;
        stall_prev = 1'b0; aborted = 1'b0; prev_pack = '0;
        @(negedge clk);
        start = 1'b1;
        layer = LAYER_W'(lay);
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check_eq("busy_after_start", 64'(busy), 1);
        while (cyc < 200 && done_cyc < 0 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (mode != 0) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (wr_cyc > 0 && cyc == wr_cyc + 1) begin
                check_eq("wr_err_busy", 64'(wr_err), 1);
                wr_en = 1'b0;
            end
            if (cyc == wr_cyc) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = WT_AW'(12); wr_data = 16'h0bad;
            end
            cur_pack = 64'({out_wt, out_bias, out_neuron, out_input, out_last_in, out_last});
            if (stall_prev) check_eq("stall_hold", cur_pack, prev_pack);
            stall_prev = out_valid && !out_ready;
            prev_pack = cur_pack;
            if (done) done_cyc = cyc;
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
            end
            if (out_valid && out_ready) begin
                if (rst_beat == nb + 1) begin
                    rst = 1'b1;
                    aborted = 1'b1;
                end else begin
                    jj = nb / nin;
                    ii = nb % nin;
                    check_eq("wt", 64'(out_wt), 64'(wb + nb));
                    check_eq("bias", 64'(out_bias), 64'(bias0 + jj));
                    check_eq("neuron", 64'(out_neuron), 64'(jj));
                    check_eq("input", 64'(out_input), 64'(ii));
                    check_eq("last_in", 64'(out_last_in), 64'(ii == nin - 1));
                    check_eq("last", 64'(out_last), 64'(nb == nin * nout - 1));
                    last_acc = cyc;
                    nb++;
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            check_eq("rst_valid", 64'(out_valid), 0);
            check_eq("rst_busy", 64'(busy), 0);
            check_eq("rst_done", 64'(done), 0);
            seen_bad = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done || out_valid || busy) seen_bad = 1'b1;
            end
            check_eq("rst_quiet", 64'(seen_bad), 0);
        end else begin
            check_eq("done_seen", 64'(done_cyc >= 0), 1);
            check_eq("beat_count", 64'(nb), 64'(nin * nout));
            check_eq("first_valid_lat", 64'(first_v), 64'(lay + 2));
            check_eq("done_after_last", 64'(done_cyc), 64'(last_acc + 1));
            check_eq("busy_at_done", 64'(busy), 0);
            if (mode == 0) check_eq("valid_cycles", 64'(nvalid), 64'(nin * nout));
            @(negedge clk);
            check_eq("done_pulse", 64'(done), 0);
        end
        out_ready = 1'b0;
    endtask

    task automatic cfg_reject(input int lay, input string tag);
        logic seen_v;
        @(negedge clk);
        start = 1'b1;
        layer = LAYER_W'(lay);
        @(negedge clk);
        start = 1'b0;
        check_eq(tag, 64'(cfg_err), 1);
        check_eq("rej_busy", 64'(busy), 0);
        @(negedge clk);
        check_eq("rej_pulse", 64'(cfg_err), 0);
        seen_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen_v = 1'b1;
        end
        check_eq("rej_quiet", 64'(seen_v), 0);
    endtask

    task automatic cfg_range_reject(input int lay);
        logic seen_e, seen_v;
        seen_e = 1'b0;
        seen_v = 1'b0;
        @(negedge clk);
        start = 1'b1;
        layer = LAYER_W'(lay);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (cfg_err) seen_e = 1'b1;
            if (out_valid) seen_v = 1'b1;
            @(negedge clk);
        end
        check_eq("range_cfg_err", 64'(seen_e), 1);
        check_eq("range_no_valid", 64'(seen_v), 0);
        check_eq("range_idle", 64'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        layer = '0;
        wr_en = 1'b0;
        wr_sel = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        out_ready = 1'b0;
        set_sizes(3, 4, 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: reset state, then load and read back layer 1
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_done", 64'(done), 0);
        check_eq("rst_cfg_err", 64'(cfg_err), 0);
        check_eq("rst_wr_err", 64'(wr_err), 0);
        check_eq("rst_fields",
                 64'({out_wt, out_bias, out_neuron, out_input, out_last_in, out_last}), 0);
        for (int a = 0; a < 20; a++) do_write(1'b0, a, a, 1'b0, "load_wt");
        for (int b = 0; b < 6; b++) do_write(1'b1, b, 100 + b, 1'b0, "load_bias");
        stream_layer(1, 3, 4, 0, 100, 0, 0, 0);

        // T2 / T3: layer 2 with steady and toggling ready
        stream_layer(2, 4, 2, 12, 104, 0, 0, 0);
        stream_layer(2, 4, 2, 12, 104, 1, 0, 0);

        // T4: rejected starts
        cfg_reject(0, "cfg_err_layer0");
        cfg_reject(6, "cfg_err_layer6");
        set_sizes(3, 4, 0);
        cfg_reject(2, "cfg_err_nout0");
        set_sizes(40, 40, 2);
        cfg_range_reject(2);
        set_sizes(3, 4, 2);

        // T5: load while streaming is dropped; edge addresses in idle
        stream_layer(2, 4, 2, 12, 104, 0, 0, 6);
        stream_layer(2, 4, 2, 12, 104, 0, 0, 0);
        do_write(1'b0, 511, 16'h1234, 1'b0, "wr_top_ok");
        do_write(1'b1, 64, 16'h1234, 1'b1, "wr_bias_oor");

        // T6: reset mid-layer, then a full replay
        stream_layer(2, 4, 2, 12, 104, 0, 3, 0);
        stream_layer(2, 4, 2, 12, 104, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
